// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared rotate-direction encodings and requester id type
// Contents:
//   ROT_LEFT / ROT_RIGHT : direction encodings seen on the *_dir inputs
//   req_id_t             : one-bit requester index (requester 0 or 1)
package shift_pkg;

    localparam logic ROT_LEFT  = 1'b1;
    localparam logic ROT_RIGHT = 1'b0;

    typedef enum logic {
        REQ_ID_0 = 1'b0,
        REQ_ID_1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/rotator_core.sv
// rtl/rotator_core.sv - purely combinational N-bit rotator
// Ports:
//   data   in  N          operand
//   amt    in  $clog2(N)  rotate amount, 0 passes data through
//   dir    in  1          ROT_LEFT rotates left, ROT_RIGHT rotates right
//   result out N          rotated operand
module rotator_core
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         data,
    input  logic [$clog2(N)-1:0] amt,
    input  logic                 dir,
    output logic [N-1:0]         result
);

    localparam int AW = $clog2(N);

    logic [AW-1:0] w_idx;

    // Each output bit picks its source bit; because N is a power of two the
    // AW-bit index arithmetic wraps modulo N for free.
    always_comb begin
        result = '0;
        w_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (dir == ROT_LEFT) begin
                w_idx = AW'(i) - amt;
            end else begin
                w_idx = AW'(i) + amt;
            end
            result[i] = data[w_idx];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end for a shared rotator
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (bit i = requester i)
//   reqX_data/amt/dir   operand, rotate amount, direction of requester X
//   out_valid/out_ready registered result handshake
//   out_data, out_id    rotated result and owning requester
//   done_count          results consumed downstream, wraps at 2^CW
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [N-1:0]         req0_data,
    input  logic [N-1:0]         req1_data,
    input  logic [$clog2(N)-1:0] req0_amt,
    input  logic [$clog2(N)-1:0] req1_amt,
    input  logic                 req0_dir,
    input  logic                 req1_dir,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic                 out_id,
    output logic [CW-1:0]        done_count
);

    localparam int AW = $clog2(N);

    logic            r_out_valid;
    logic [N-1:0]    r_out_data;
    req_id_t         r_out_id;
    req_id_t         r_last_grant;
    logic [CW-1:0]   r_done_count;

    logic            w_slot_free;
    logic            w_any_valid;
    req_id_t         w_grant_id;
    logic [1:0]      w_req_ready;
    logic            w_xfer;
    logic [N-1:0]    w_rot_data;
    logic [AW-1:0]   w_rot_amt;
    logic            w_rot_dir;
    logic [N-1:0]    w_rot_result;

    // Grant decision uses only valids and the last accepted requester, so
    // req_ready never waits on operand fields.
    always_comb begin
        w_slot_free = !r_out_valid || out_ready;
        w_any_valid = |req_valid;
        if (req_valid == 2'b11) begin
            w_grant_id = req_id_t'(~r_last_grant);
        end else if (req_valid[1]) begin
            w_grant_id = REQ_ID_1;
        end else begin
            w_grant_id = REQ_ID_0;
        end

        w_req_ready = 2'b00;
        if (!rst && w_slot_free && w_any_valid) begin
            if (w_grant_id == REQ_ID_1) begin
                w_req_ready = 2'b10;
            end else begin
                w_req_ready = 2'b01;
            end
        end
        w_xfer = |(req_valid & w_req_ready);
    end

    // Operand mux in front of the single shared rotator.
    always_comb begin
        if (w_grant_id == REQ_ID_1) begin
            w_rot_data = req1_data;
            w_rot_amt  = req1_amt;
            w_rot_dir  = req1_dir;
        end else begin
            w_rot_data = req0_data;
            w_rot_amt  = req0_amt;
            w_rot_dir  = req0_dir;
        end
    end

    rotator_core #(
        .N (N)
    ) u_rotator (
        .data   (w_rot_data),
        .amt    (w_rot_amt),
        .dir    (w_rot_dir),
        .result (w_rot_result)
    );

    // Result register: a new grant may overwrite a result that is being
    // consumed in the same cycle, giving one result per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_id     <= REQ_ID_0;
            r_last_grant <= REQ_ID_1;
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_rot_result;
            r_out_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_done_count <= r_done_count + 1'b1;
        end
    end

    assign req_ready  = w_req_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_id     = r_out_id;
    assign done_count = r_done_count;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed table-driven bench for shift_arbiter
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [7:0]  req0_data, req1_data;
    logic [2:0]  req0_amt, req1_amt;
    logic        req0_dir, req1_dir;
    logic        out_ready;

    logic [1:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_id;
    logic [15:0] done_count;

    logic [1:0]  req_ready4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic        out_id4;
    logic [3:0]  done_count4;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.N(8), .CW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_amt(req0_amt), .req1_amt(req1_amt),
        .req0_dir(req0_dir), .req1_dir(req1_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .done_count(done_count)
    );

    shift_arbiter #(.N(8), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_amt(req0_amt), .req1_amt(req1_amt),
        .req0_dir(req0_dir), .req1_dir(req1_dir),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_id(out_id4), .done_count(done_count4)
    );

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [2:0] a0;
        logic       dir0;
        logic [7:0] d1;
        logic [2:0] a1;
        logic       dir1;
        logic [1:0] exp_ready;
        logic [7:0] exp_data;
        logic       exp_id;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 8'h81, 3'd1, 1'b1, 8'h00, 3'd0, 1'b0, 2'b01, 8'h03, 1'b0};
        vecs[1] = '{2'b10, 8'h00, 3'd0, 1'b0, 8'hA5, 3'd3, 1'b0, 2'b10, 8'hB4, 1'b1};
        vecs[2] = '{2'b10, 8'h00, 3'd0, 1'b0, 8'hA5, 3'd0, 1'b0, 2'b10, 8'hA5, 1'b1};
        vecs[3] = '{2'b01, 8'hA5, 3'd0, 1'b1, 8'h00, 3'd0, 1'b0, 2'b01, 8'hA5, 1'b0};
        vecs[4] = '{2'b01, 8'h01, 3'd7, 1'b1, 8'h00, 3'd0, 1'b0, 2'b01, 8'h80, 1'b0};
        vecs[5] = '{2'b10, 8'h00, 3'd0, 1'b0, 8'h01, 3'd1, 1'b0, 2'b10, 8'h80, 1'b1};
        vecs[6] = '{2'b01, 8'h3C, 3'd4, 1'b1, 8'h00, 3'd0, 1'b0, 2'b01, 8'hC3, 1'b0};
        vecs[7] = '{2'b10, 8'h00, 3'd0, 1'b0, 8'hF0, 3'd2, 1'b0, 2'b10, 8'h3C, 1'b1};
        vecs[8] = '{2'b01, 8'h96, 3'd5, 1'b0, 8'h00, 3'd0, 1'b0, 2'b01, 8'hB4, 1'b0};

        // Reset held for 3 cycles with both requests asserted.
        rst = 1'b1; out_ready = 1'b1; req_valid = 2'b11;
        req0_data = 8'h11; req0_amt = 3'd0; req0_dir = 1'b1;
        req1_data = 8'h22; req1_amt = 3'd0; req1_dir = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_done_count", 32'(done_count), 32'd0);
        end
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);

        // Both valid from the first cycle after reset: 0,1,0,1,0,1.
        rst = 1'b0;
        #1;
        check("first_grant_ready", 32'(req_ready), 32'b01);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_id", 32'(out_id), 32'(i % 2));
            check("rr_out_data", 32'(out_data), (i % 2 == 0) ? 32'h11 : 32'h22);
            check("rr_next_ready", 32'(req_ready), (i % 2 == 0) ? 32'b10 : 32'b01);
        end
        req_valid = 2'b00;
        tick();
        exp_done = 6;
        check("rr_done_count", 32'(done_count), 32'(exp_done));
        check("rr_drain_valid", 32'(out_valid), 32'd0);

        // Single-request rotation vectors.
        for (int v = 0; v < 9; v++) begin
            req_valid = vecs[v].valid;
            req0_data = vecs[v].d0; req0_amt = vecs[v].a0; req0_dir = vecs[v].dir0;
            req1_data = vecs[v].d1; req1_amt = vecs[v].a1; req1_dir = vecs[v].dir1;
            #1;
            check("vec_req_ready", 32'(req_ready), 32'(vecs[v].exp_ready));
            tick();
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check("vec_out_data", 32'(out_data), 32'(vecs[v].exp_data));
            check("vec_out_id", 32'(out_id), 32'(vecs[v].exp_id));
            req_valid = 2'b00;
            tick();
            exp_done++;
        end
        check("vec_done_count", 32'(done_count), 32'(exp_done));

        // Backpressure: result held, no grants, then requester 1 served.
        req_valid = 2'b01;
        req0_data = 8'h81; req0_amt = 3'd1; req0_dir = 1'b1;
        req1_data = 8'hA5; req1_amt = 3'd3; req1_dir = 1'b0;
        tick();
        check("stall_load", 32'(out_data), 32'h03);
        out_ready = 1'b0;
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
            check("stall_out_data", 32'(out_data), 32'h03);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_id", 32'(out_id), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 32'(req_ready), 32'b10);
        tick();
        exp_done++;
        check("release_out_id", 32'(out_id), 32'd1);
        check("release_out_data", 32'(out_data), 32'hB4);
        req_valid = 2'b00;
        tick();
        exp_done++;
        check("stall_done_count", 32'(done_count), 32'(exp_done));
        check("stall_done_count_cw4", 32'(done_count4), 32'(exp_done % 16));

        // 17 consumed results after a fresh reset: CW=4 counter wraps to 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 2'b01;
        req0_data = 8'h5A; req0_amt = 3'd2; req0_dir = 1'b1;
        for (int c = 0; c < 17; c++) tick();
        req_valid = 2'b00;
        tick();
        check("wrap_done_count16", 32'(done_count), 32'd17);
        check("wrap_done_count4", 32'(done_count4), 32'd1);

        // Reset while a result is held: dropped without a count.
        req_valid = 2'b01;
        tick();
        check("midrst_loaded", 32'(out_valid), 32'd1);
        rst = 1'b1;
        req_valid = 2'b01;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_done_count", 32'(done_count), 32'd0);
        check("midrst_done_count4", 32'(done_count4), 32'd0);
        rst = 1'b0;
        req_valid = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning the data width in bits; N SHALL be a power of two, N >= 2.
REQ-002 SHALL have parameter CW, default 16, meaning the completed-transaction counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports req_valid[1:0]  input  2  per-requester request valid.
REQ-006 SHALL have ports req_ready[1:0]  output  2  per-requester accept; the transfer occurs when valid and ready are both 1.
REQ-007 SHALL have ports req0_data, req1_data  input  N  operand per requester.
REQ-008 SHALL have ports req0_amt, req1_amt  input  $clog2(N)  rotate amount per requester.
REQ-009 SHALL have ports req0_dir, req1_dir  input  1  direction per requester: 1 = rotate left, 0 = rotate right.
REQ-010 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_data  output  N  rotated result.
REQ-013 SHALL have port out_id  output  1  index of the requester that owns out_data.
REQ-014 SHALL have port done_count  output  CW  count of results consumed downstream.

Function
REQ-015 SHALL share one combinational rotator between two requesters: left rotate by amt when dir=1, right rotate when dir=0, and amt=0 passes the operand through.
REQ-016 SHALL register the result: the grant in cycle t makes out_valid=1 with data in cycle t+1, so latency is 1 cycle.
REQ-017 SHALL define slot_free = !out_valid || out_ready; req_ready[i] SHALL be 1 only for the granted requester i and only when slot_free=1.
REQ-018 SHALL arbitrate round-robin: if exactly one request is valid, that requester is granted; if both are valid, the requester other than last_grant is granted.
REQ-019 SHALL update last_grant only on an accepted transfer.
REQ-020 SHALL keep out_data, out_id and out_valid stable while out_valid=1 and out_ready=0, and accept no new request in that state.
REQ-021 SHALL, when out_valid=1, out_ready=1 and a request is granted in the same cycle, load the new result with no bubble, so throughput is 1 per cycle.
REQ-022 SHALL clear out_valid when out_ready=1 and no transfer occurs.
REQ-023 SHALL increment done_count on every cycle with out_valid && out_ready, wrapping from 2^CW-1 to 0.
REQ-024 SHALL have req_ready depend combinationally on req_valid and out_ready only, never on data, amt or dir.

Reset
REQ-025 SHALL, while rst=1, force out_valid=0, out_data=0, out_id=0, done_count=0, last_grant=1 and req_ready=2'b00.
REQ-026 SHALL, when rst is asserted mid-operation, discard any held result without a handshake and leave done_count unincremented in that cycle.
REQ-027 SHALL grant requester 0 first when both requests are valid in the first cycle after reset.

Structure
REQ-028 SHALL take the direction encoding constants (ROT_LEFT=1, ROT_RIGHT=0) and the requester-id type from a shared package, shift_pkg.
REQ-029 SHALL instantiate the rotator as one sub-module, rotator_core, parameter N, purely combinational (data, amt, dir -> result), reusable elsewhere in the codebase.
REQ-030 SHALL keep the arbiter, result register and counter in shift_arbiter itself, with no further sub-modules.

Verification (N=8)
REQ-031 SHALL cover: hold rst=1 for 3 cycles -> out_valid=0, req_ready=00 and done_count=0 throughout.
REQ-032 SHALL cover: req0 with data 8'h81, amt 1, dir 1 and out_ready=1 -> next cycle out_data=8'h03, out_id=0, out_valid=1.
REQ-033 SHALL cover: req1 with data 8'hA5, amt 3, dir 0 -> out_data=8'hB4, out_id=1; the same request with amt 0 -> 8'hA5.
REQ-034 SHALL cover: both requesters valid for 6 cycles with out_ready=1 -> out_id sequence 0,1,0,1,0,1 and done_count=6.
REQ-035 SHALL cover: out_ready=0 for 4 cycles with both requests valid -> out_data stable and req_ready=00; on release, the next grant goes to the requester not yet served.
REQ-036 SHALL cover: CW=4, 17 consumed results -> done_count=1; rst asserted while out_valid=1 -> out_valid=0 next cycle with no increment.
